ipsxe_fft_test_seq: RTL and testbench

Multi-channel on-board test sequencer for FFT example designs. It debounces the start button and issues one start pulse per run to NUM_CH frame generator/checker pairs. Runs are sequenced in single, N-run or continuous mode, with a completion watchdog, per-channel sticky error locks and run/fail counters. It sits between the board I/O and the frame_gen/fft/frame_chk channels, and replaces the hand-written start/debounce/error-lock logic in onboard tops.

---
 rtl/ipsxe_fft_test_seq.sv | 137 +++++++++++++
 tb/tb_ipsxe_fft_test_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ipsxe_fft_test_seq.sv
// ipsxe_fft_test_seq: debounced start, run sequencing, watchdog and sticky error capture for FFT test channels
module ipsxe_fft_test_seq #(
  parameter int NUM_CH       = 1,
  parameter int DB_CNT_MAX   = 2048,
  parameter int DB_CNT_WIDTH = 12,
  parameter int RUN_NUM      = 4,
  parameter int GAP_CYC      = 16,
  parameter int TIMEOUT_CYC  = 1048576,
  parameter int TIMEOUT_W    = 21,
  parameter int RUN_CNT_W    = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_aclken,
  input  logic                   i_start_test,
  input  logic                   i_stop,
  input  logic [1:0]             i_mode,
  input  logic [NUM_CH-1:0]      i_chk_finished,
  input  logic [NUM_CH-1:0]      i_err,
  input  logic [3*NUM_CH-1:0]    i_alm,
  output logic                   o_start_pulse,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [NUM_CH-1:0]      o_err_ch,
  output logic                   o_timeout,
  output logic                   o_err,
  output logic [RUN_CNT_W-1:0]   o_run_cnt,
  output logic [RUN_CNT_W-1:0]   o_fail_cnt
);
  localparam int GW = $clog2(GAP_CYC + 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, ARM, WAIT, GAP, DONE} state_t;
  state_t                 state;
  logic [2:0]             sync;
  logic [DB_CNT_WIDTH-1:0] db_cnt;
  logic [TIMEOUT_W-1:0]   wd;
  logic [GW-1:0]          gap;
  logic                   stop_l, run_fail;
  logic [NUM_CH-1:0]      hit;
  logic                   btn_edge, fail_now, stop_now, last;
  logic [RUN_CNT_W-1:0]   run_nx, fail_nx;
  // per-channel error: checker error or any nonzero FFT alarm bit
  always_comb begin
    hit = '0;
    for (int c = 0; c < NUM_CH; c++) hit[c] = i_err[c] | (|i_alm[3*c +: 3]);
  end
  assign btn_edge = sync[1] & ~sync[2];
  assign fail_now = run_fail | (|hit);
  assign stop_now = stop_l | i_stop;
  assign run_nx   = &o_run_cnt ? o_run_cnt : o_run_cnt + 1'b1;
  assign fail_nx  = &o_fail_cnt ? o_fail_cnt : o_fail_cnt + 1'b1;
  assign last     = i_mode == 2'b01 ? run_nx == RUN_CNT_W'(RUN_NUM) : i_mode != 2'b10;
  assign o_err    = |o_err_ch | o_timeout;
  // sequencer FSM with registered outputs; errors in the LAUNCH cycle are dropped by the launch clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      sync          <= 3'b111;
      db_cnt        <= '0;
      wd            <= '0;
      gap           <= '0;
      stop_l        <= 1'b0;
      run_fail      <= 1'b0;
      o_start_pulse <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err_ch      <= '0;
      o_timeout     <= 1'b0;
      o_run_cnt     <= '0;
      o_fail_cnt    <= '0;
    end else if (i_aclken) begin
      sync <= {sync[1:0], i_start_test};
      if (o_busy && i_stop) stop_l <= 1'b1;
      if (o_busy && state != LAUNCH && |hit) begin
        o_err_ch <= o_err_ch | hit;
        run_fail <= 1'b1;
      end
      case (state)
        IDLE, DONE:
          if (db_cnt == '0) begin
            if (btn_edge) db_cnt <= DB_CNT_WIDTH'(1);
          end else if (i_stop) db_cnt <= '0;
          else if (db_cnt == DB_CNT_WIDTH'(DB_CNT_MAX - 1)) begin
            db_cnt        <= '0;
            state         <= LAUNCH;
            o_start_pulse <= 1'b1;
            o_busy        <= 1'b1;
            o_done        <= 1'b0;
            o_err_ch      <= '0;
            o_timeout     <= 1'b0;
            o_run_cnt     <= '0;
            o_fail_cnt    <= '0;
            stop_l        <= 1'b0;
          end else db_cnt <= db_cnt + 1'b1;
        LAUNCH: begin
          o_start_pulse <= 1'b0;
          run_fail      <= 1'b0;
          state         <= ARM;
        end
        ARM: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT:
          if (&i_chk_finished) begin
            o_run_cnt <= run_nx;
            if (fail_now) o_fail_cnt <= fail_nx;
            gap <= '0;
            if (last || stop_now) begin
              state  <= DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else state <= GAP;
          end else if (wd == TIMEOUT_W'(TIMEOUT_CYC - 1)) begin
            o_timeout  <= 1'b1;
            run_fail   <= 1'b1;
            o_run_cnt  <= run_nx;
            o_fail_cnt <= fail_nx;
            state      <= DONE;
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
          end else wd <= wd + 1'b1;
        GAP:
          if (gap == GW'(GAP_CYC - 1)) begin
            if (stop_now) begin
              state  <= DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else begin
              state         <= LAUNCH;
              o_start_pulse <= 1'b1;
            end
          end else gap <= gap + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ipsxe_fft_test_seq.sv
// tb_ipsxe_fft_test_seq: directed sessions with a done-triggered scoreboard
module tb_ipsxe_fft_test_seq;
  localparam int GC = 16;
  logic        clk = 1'b0, rst = 1'b1, acl = 1'b1, btn = 1'b0, stp = 1'b0;
  logic [1:0]  mode = 2'b00, fin = 2'b11, err = 2'b00;
  logic [5:0]  alm = 6'b0;
  logic        o_start_pulse, o_busy, o_done, o_timeout, o_err;
  logic [1:0]  o_err_ch;
  logic [15:0] o_run_cnt, o_fail_cnt;
  typedef struct {int run; int fail; int ech; int to; int np;} exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0, pulses = 0, acnt = 0, lastp = 0;
  bit div = 0, hang = 0;

  ipsxe_fft_test_seq #(
    .NUM_CH(2), .DB_CNT_MAX(8), .DB_CNT_WIDTH(4), .RUN_NUM(4), .GAP_CYC(GC),
    .TIMEOUT_CYC(32), .TIMEOUT_W(6), .RUN_CNT_W(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_aclken(acl), .i_start_test(btn), .i_stop(stp),
    .i_mode(mode), .i_chk_finished(fin), .i_err(err), .i_alm(alm),
    .o_start_pulse(o_start_pulse), .o_busy(o_busy), .o_done(o_done), .o_err_ch(o_err_ch),
    .o_timeout(o_timeout), .o_err(o_err), .o_run_cnt(o_run_cnt), .o_fail_cnt(o_fail_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (acl) acnt <= acnt + 1;

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(int r, int f, int e, int t, int n);
    exp_t x;
    x.run = r; x.fail = f; x.ech = e; x.to = t; x.np = n;
    q.push_back(x);
  endtask

  // clock enable: always on, or one cycle in three
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      acl = div ? (ph == 0) : 1'b1;
      ph = (ph + 1) % 3;
    end
  end

  // checker model: drop finished on a start pulse, raise it 20 clocks later unless hung
  initial forever begin
    @(negedge clk);
    if (o_start_pulse && !rst) begin
      fin = 2'b00;
      repeat (20) @(negedge clk);
      while (hang) @(negedge clk);
      fin = 2'b11;
    end
  end

  // monitor: count pulses, check spacing, compare results when o_done rises
  initial begin
    bit pd, dd;
    exp_t e;
    pd = 0; dd = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pulses = 0; pd = 0; dd = 0;
      end else begin
        if (o_start_pulse && !pd) begin
          if (pulses > 0) check("pulse_spacing_ge_19", int'(acnt - lastp >= GC + 3), 1);
          lastp = acnt;
          pulses++;
        end
        if (o_done && !dd) begin
          if (q.size() == 0) check("unexpected_done", 1, 0);
          else begin
            e = q.pop_front();
            check("run_cnt", int'(o_run_cnt), e.run);
            check("fail_cnt", int'(o_fail_cnt), e.fail);
            check("err_ch", int'(o_err_ch), e.ech);
            check("timeout", int'(o_timeout), e.to);
            check("o_err", int'(o_err), int'(e.ech != 0 || e.to != 0));
            check("busy_at_done", int'(o_busy), 0);
            check("pulse_count", pulses, e.np);
            if (e.to != 0) check("watchdog_latency", acnt - lastp, 34);
          end
          pulses = 0;
        end
        pd = o_start_pulse;
        dd = o_done;
      end
    end
  end

  // latency in enabled edges from button rise: 2 sync stages, edge load, 7 debounce counts
  task automatic await_pulse(int a0, int lat);
    int b;
    b = 0;
    while (!o_start_pulse && b < 500) begin
      @(negedge clk);
      b++;
    end
    check("launch_latency", acnt - a0, lat);
  endtask

  task automatic press();
    int a0;
    a0 = acnt;
    btn = 1'b1;
    await_pulse(a0, 10);
  endtask

  task automatic release_btn();
    btn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_pulses(int n);
    int b;
    b = 0;
    while (pulses < n && b < 3000) begin
      @(negedge clk);
      b++;
    end
    check($sformatf("pulse%0d_seen", n), int'(pulses >= n), 1);
  endtask

  task automatic wait_done();
    int b;
    b = 0;
    while (!o_done && b < 3000) begin
      @(negedge clk);
      b++;
    end
    check("done_seen", int'(o_done), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int a0;
    repeat (3) @(negedge clk);
    check("rst_pulse", int'(o_start_pulse), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_err", int'(o_err), 0);
    check("rst_run_cnt", int'(o_run_cnt), 0);
    check("rst_fail_cnt", int'(o_fail_cnt), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    // single run
    mode = 2'b00; push_exp(1, 0, 0, 0, 1);
    press(); wait_done(); release_btn();
    // N-run with an error in run 3
    mode = 2'b01; push_exp(4, 1, 2, 0, 4);
    press(); wait_pulses(3);
    repeat (3) @(negedge clk);
    err = 2'b10; @(negedge clk); err = 2'b00;
    wait_done(); release_btn();
    // continuous, stop during WAIT of run 5
    mode = 2'b10; push_exp(5, 0, 0, 0, 5);
    press(); wait_pulses(5);
    repeat (3) @(negedge clk);
    stp = 1'b1; @(negedge clk); stp = 1'b0;
    wait_done(); release_btn();
    // single run with a channel-1 alarm
    mode = 2'b00; push_exp(1, 1, 2, 0, 1);
    press(); wait_pulses(1);
    repeat (3) @(negedge clk);
    alm = 6'b100000; @(negedge clk); alm = 6'b0;
    wait_done(); release_btn();
    // watchdog, mode 11 acts as single
    mode = 2'b11; hang = 1; push_exp(1, 1, 0, 1, 1);
    press(); wait_done();
    hang = 0; release_btn();
    // stop during debounce cancels the launch
    btn = 1'b1;
    repeat (4) @(negedge clk);
    stp = 1'b1; @(negedge clk); stp = 1'b0;
    repeat (40) @(negedge clk);
    check("cancel_no_pulse", pulses, 0);
    check("cancel_busy", int'(o_busy), 0);
    check("cancel_done_held", int'(o_done), 1);
    release_btn();
    // bounced button from DONE: one pulse, previous results cleared
    mode = 2'b00; push_exp(1, 0, 0, 0, 1);
    a0 = acnt;
    btn = 1'b1; @(negedge clk); btn = 1'b0; @(negedge clk);
    btn = 1'b1; @(negedge clk); btn = 1'b0; @(negedge clk);
    btn = 1'b1;
    await_pulse(a0, 10);
    wait_done(); release_btn();
    // aclken 1-of-3, reset during GAP with the button held
    div = 1; mode = 2'b01;
    repeat (6) @(negedge clk);
    press();
    repeat (40) @(negedge clk);
    check("gap_busy", int'(o_busy), 1);
    check("gap_run_cnt", int'(o_run_cnt), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_pulse", int'(o_start_pulse), 0);
    check("mid_rst_busy", int'(o_busy), 0);
    check("mid_rst_done", int'(o_done), 0);
    check("mid_rst_err", int'(o_err), 0);
    check("mid_rst_run_cnt", int'(o_run_cnt), 0);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("held_btn_no_pulse", pulses, 0);
    check("held_btn_busy", int'(o_busy), 0);
    check("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
